// File: rtl/pid_mult_sched.sv
// pid_mult_sched
//   Sequencer for the servo PID datapath. One shared fixed-point multiplier
//   produces the P, I and D terms on successive cycles. It then updates the
//   integrator and the derivative history, and registers the saturated
//   control output for the PWM stage.
//
// Ports
//   clk      system clock
//   rst      synchronous reset, active-low
//   start    sample strobe; ek/kp/ki/kd are latched when it is accepted
//   ek       signed error e(k)
//   kp/ki/kd signed gains, FRAC fractional bits (1.0 = 2**FRAC)
//   clr_int  zero the integrator and e_prev (honoured only while idle)
//   u_out    signed control output, registered, held between samples
//   busy     high from accept until the cycle after done
//   done     one-cycle pulse when u_out updates
//   overrun  sticky: start arrived while busy (cleared only by reset)
module pid_mult_sched #(
  parameter int N     = 19,
  parameter int FRAC  = 8,
  parameter int I_LIM = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] ek,
  input  logic [N-1:0] kp,
  input  logic [N-1:0] ki,
  input  logic [N-1:0] kd,
  input  logic         clr_int,
  output logic [N-1:0] u_out,
  output logic         busy,
  output logic         done,
  output logic         overrun
);

  typedef enum logic [2:0] {S_IDLE, S_MP, S_MI, S_MD, S_SUM} state_e;

  localparam logic signed [N:0] I_MAX = (N+1)'(I_LIM);
  localparam logic signed [N:0] I_MIN = -I_MAX;

  // Clamp a sign-extended 2N-bit value into the signed N-bit range.
  function automatic logic signed [N-1:0] sat_n(input logic signed [2*N-1:0] v);
    logic signed [2*N-1:0] max_v;
    logic signed [2*N-1:0] min_v;
    max_v = $signed({{(N+1){1'b0}}, {(N-1){1'b1}}});
    min_v = $signed({{(N+1){1'b1}}, {(N-1){1'b0}}});
    if (v > max_v)      return max_v[N-1:0];
    else if (v < min_v) return min_v[N-1:0];
    else                return v[N-1:0];
  endfunction

  state_e              state_q;
  logic signed [N-1:0] e_q, kp_q, ki_q, kd_q, diff_q;
  logic signed [N-1:0] p_q, d_q, i_acc_q, e_prev_q, u_q;
  logic                busy_q, done_q, overrun_q;

  logic signed [N-1:0]   mul_a, mul_b, mul_d;
  logic signed [2*N-1:0] prod;
  logic signed [N:0]     i_sum;
  logic signed [N-1:0]   i_acc_d;
  logic signed [N-1:0]   e_base;
  logic signed [N:0]     diff_w;
  logic signed [N-1:0]   diff_d;
  logic signed [N+1:0]   u_sum;
  logic signed [N-1:0]   u_d;

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      S_MP:    begin mul_a = kp_q; mul_b = e_q;    end
      S_MI:    begin mul_a = ki_q; mul_b = e_q;    end
      S_MD:    begin mul_a = kd_q; mul_b = diff_q; end
      default: ;
    endcase

    // The single shared multiplier: full 2N-bit product, floor shift, saturate.
    prod  = mul_a * mul_b;
    mul_d = sat_n(prod >>> FRAC);

    // Integrator: N+1-bit sum so the clamp sees the true value.
    i_sum = {i_acc_q[N-1], i_acc_q} + {mul_d[N-1], mul_d};
    if (i_sum > I_MAX)      i_acc_d = I_MAX[N-1:0];
    else if (i_sum < I_MIN) i_acc_d = I_MIN[N-1:0];
    else                    i_acc_d = i_sum[N-1:0];

    // clr_int with start: the clear wins, so diff is taken against zero.
    e_base = clr_int ? '0 : e_prev_q;
    diff_w = {ek[N-1], ek} - {e_base[N-1], e_base};
    diff_d = sat_n({{(N-1){diff_w[N]}}, diff_w});

    u_sum = {{2{p_q[N-1]}}, p_q} + {{2{i_acc_q[N-1]}}, i_acc_q} + {{2{d_q[N-1]}}, d_q};
    u_d   = sat_n({{(N-2){u_sum[N+1]}}, u_sum});
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      state_q   <= S_IDLE;
      e_q       <= '0;
      kp_q      <= '0;
      ki_q      <= '0;
      kd_q      <= '0;
      diff_q    <= '0;
      p_q       <= '0;
      d_q       <= '0;
      i_acc_q   <= '0;
      e_prev_q  <= '0;
      u_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (done_q) begin
            // Done cycle still counts as busy: start here is an overrun.
            done_q <= 1'b0;
            busy_q <= 1'b0;
            if (start) overrun_q <= 1'b1;
          end else begin
            if (clr_int) begin
              i_acc_q  <= '0;
              e_prev_q <= '0;
            end
            if (start) begin
              e_q     <= $signed(ek);
              kp_q    <= $signed(kp);
              ki_q    <= $signed(ki);
              kd_q    <= $signed(kd);
              diff_q  <= diff_d;
              busy_q  <= 1'b1;
              state_q <= S_MP;
            end
          end
        end
        S_MP: begin
          p_q     <= mul_d;
          state_q <= S_MI;
        end
        S_MI: begin
          i_acc_q <= i_acc_d;
          state_q <= S_MD;
        end
        S_MD: begin
          d_q     <= mul_d;
          state_q <= S_SUM;
        end
        S_SUM: begin
          u_q      <= u_d;
          e_prev_q <= e_q;
          done_q   <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (state_q != S_IDLE && start) overrun_q <= 1'b1;
    end
  end

  assign u_out   = u_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule
